mem_access: RTL

- Load/store stage directly downstream of the execute/control stage.
- Consumes that stage's memory request (mem_re/mem_we, address, store data, byte_sel, un_sign) and runs one data-bus transaction per request over a req/ack handshake.
- Aligns store lanes and sign- or zero-extends load data, then writes the load result to the register file.
- Holds the PC while a transaction is outstanding.

---
 rtl/mem_access.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Load/store stage: one req/ack bus transaction per request, with lane alignment and load extension.
// Optional bus-ack timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int RAW     = 5,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mem_re_i,
    input  logic           mem_we_i,
    input  logic [AW-1:0]  mem_addr_i,
    input  logic [DW-1:0]  mem_wdata_i,
    input  logic [3:0]     byte_sel_i,
    input  logic           un_sign_i,
    input  logic [RAW-1:0] rd_waddr_i,
    output logic           bus_req_o,
    output logic           bus_we_o,
    output logic [AW-1:0]  bus_addr_o,
    output logic [3:0]     bus_wstrb_o,
    output logic [DW-1:0]  bus_wdata_o,
    input  logic           bus_ack_i,
    input  logic [DW-1:0]  bus_rdata_i,
    output logic           rd_we_o,
    output logic [RAW-1:0] rd_waddr_o,
    output logic [DW-1:0]  rd_wdata_o,
    output logic           hold_o,
    output logic           err_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] SEL_B = 4'b0001;
    localparam logic [3:0] SEL_H = 4'b0011;
    localparam logic [3:0] SEL_W = 4'b1111;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("mem_access: TIMEOUT must be within 1..255");
    end

    function automatic logic [DW-1:0] replicate_store(input logic [DW-1:0] d, input logic [3:0] sel);
        logic [DW-1:0] r;
        case (sel)
            SEL_B:   r = {4{d[7:0]}};
            SEL_H:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // un_sign set means the loaded value is sign-extended
    function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] w, input logic [3:0] sel,
                                                  input logic sgn);
        logic [DW-1:0] r;
        case (sel)
            SEL_B:   r = sgn ? {{(DW-8){w[7]}}, w[7:0]} : {{(DW-8){1'b0}}, w[7:0]};
            SEL_H:   r = sgn ? {{(DW-16){w[15]}}, w[15:0]} : {{(DW-16){1'b0}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    logic [1:0]     state_q, state_d;
    logic           bus_req_q, bus_req_d;
    logic           bus_we_q, bus_we_d;
    logic [AW-1:0]  bus_addr_q, bus_addr_d;
    logic [3:0]     bus_wstrb_q, bus_wstrb_d;
    logic [DW-1:0]  bus_wdata_q, bus_wdata_d;
    logic           rd_we_q, rd_we_d;
    logic [RAW-1:0] rd_waddr_q, rd_waddr_d;
    logic [DW-1:0]  rd_wdata_q, rd_wdata_d;
    logic           err_q, err_d;
    logic [1:0]     off_q, off_d;
    logic [3:0]     sel_q, sel_d;
    logic           sgn_q, sgn_d;
`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]     cnt_q, cnt_d;
`endif

    logic           req_s;
    logic           illegal_s;
    logic [3:0]     strb_s;
    logic [DW-1:0]  shifted_s;
    logic           hold_s;

    assign req_s     = mem_re_i | mem_we_i;
    assign illegal_s = (mem_re_i & mem_we_i)
                     | ((byte_sel_i != SEL_B) && (byte_sel_i != SEL_H) && (byte_sel_i != SEL_W))
                     | ((byte_sel_i == SEL_H) && mem_addr_i[0])
                     | ((byte_sel_i == SEL_W) && (mem_addr_i[1:0] != 2'b00));
    assign strb_s    = byte_sel_i << mem_addr_i[1:0];
    assign shifted_s = bus_rdata_i >> {off_q, 3'b000};

    // Stall upstream while a request is pending or a transaction is in flight
    always_comb begin
        hold_s = 1'b0;
        case (state_q)
            IDLE:    hold_s = req_s;
            BUSY:    hold_s = 1'b1;
            default: hold_s = 1'b0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_wdata_d = bus_wdata_q;
        rd_we_d     = 1'b0;
        rd_waddr_d  = rd_waddr_q;
        rd_wdata_d  = rd_wdata_q;
        err_d       = 1'b0;
        off_d       = off_q;
        sel_d       = sel_q;
        sgn_d       = sgn_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_s && illegal_s) begin
                    err_d = 1'b1;
                end else if (req_s) begin
                    state_d     = BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_addr_d  = {mem_addr_i[AW-1:2], 2'b00};
                    bus_wstrb_d = mem_we_i ? strb_s : 4'b0000;
                    bus_wdata_d = mem_we_i ? replicate_store(mem_wdata_i, byte_sel_i) : {DW{1'b0}};
                    rd_waddr_d  = rd_waddr_i;
                    off_d       = mem_addr_i[1:0];
                    sel_d       = byte_sel_i;
                    sgn_d       = un_sign_i;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (bus_ack_i && bus_req_q) begin
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                    if (!bus_we_q) begin
                        rd_we_d    = 1'b1;
                        rd_wdata_d = extend_load(shifted_s, sel_q, sgn_q);
                    end else begin
                        rd_we_d = 1'b0;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`else
                end else begin
                    state_d = BUSY;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {AW{1'b0}};
            bus_wstrb_q <= 4'b0000;
            bus_wdata_q <= {DW{1'b0}};
            rd_we_q     <= 1'b0;
            rd_waddr_q  <= {RAW{1'b0}};
            rd_wdata_q  <= {DW{1'b0}};
            err_q       <= 1'b0;
            off_q       <= 2'b00;
            sel_q       <= 4'b0000;
            sgn_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_wdata_q <= bus_wdata_d;
            rd_we_q     <= rd_we_d;
            rd_waddr_q  <= rd_waddr_d;
            rd_wdata_q  <= rd_wdata_d;
            err_q       <= err_d;
            off_q       <= off_d;
            sel_q       <= sel_d;
            sgn_q       <= sgn_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wstrb_o = bus_wstrb_q;
    assign bus_wdata_o = bus_wdata_q;
    assign rd_we_o     = rd_we_q;
    assign rd_waddr_o  = rd_waddr_q;
    assign rd_wdata_o  = rd_wdata_q;
    assign hold_o      = hold_s;
    assign err_o       = err_q;

endmodule
